branch_resolve_bht: RTL and testbench

Parametrised branch resolution unit for the five-stage core's EX stage. It evaluates the RV32 conditional-branch condition on forwarded operands and compares the outcome with the prediction the instruction carried down the pipe. It keeps a direct-mapped table of 2-bit saturating counters, read in IF and trained in EX. It raises a mispredict flag so the hazard unit can flush, and keeps saturating branch/mispredict statistics counters.

---
 rtl/branch_resolve_bht.sv | 89 ++++++++
 tb/tb_branch_resolve_bht.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution with a direct-mapped table of 2-bit saturating counters
// (combinational lookup in IF, training in EX) and saturating branch/mispredict statistics.
module branch_resolve_bht #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   if_pc,
  output logic                  if_pred_taken,
  input  logic                  meet_branch_ID_EX_o,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] forward_rs1,
  input  logic [DATA_WIDTH-1:0] forward_rs2,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic                  ex_pred_taken,
  input  logic                  stall_EX,
  output logic                  branch_decision,
  output logic                  mispredict,
  output logic                  illegal_branch,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned Idx = $clog2(BHT_ENTRIES);

  logic [1:0]     bht [BHT_ENTRIES];
  logic [Idx-1:0] if_idx;
  logic [Idx-1:0] ex_idx;
  logic [1:0]     ex_ctr;
  logic [1:0]     ex_ctr_next;
  logic           upd;
  logic           unused_pc_bits;

  assign if_idx = if_pc[Idx+1:2];
  assign ex_idx = ex_pc[Idx+1:2];
  assign unused_pc_bits = ^{if_pc[PC_WIDTH-1:Idx+2], if_pc[1:0],
                            ex_pc[PC_WIDTH-1:Idx+2], ex_pc[1:0]};

  // No write bypass: a same-cycle update to this index shows up next cycle.
  assign if_pred_taken = bht[if_idx][1];

  always_comb begin
    branch_decision = 1'b0;
    illegal_branch  = 1'b0;
    if (meet_branch_ID_EX_o) begin
      unique case (funct3)
        3'b000:         branch_decision = (forward_rs1 == forward_rs2);
        3'b001:         branch_decision = (forward_rs1 != forward_rs2);
        3'b100:         branch_decision = ($signed(forward_rs1) < $signed(forward_rs2));
        3'b101:         branch_decision = ($signed(forward_rs1) >= $signed(forward_rs2));
        3'b110:         branch_decision = (forward_rs1 < forward_rs2);
        3'b111:         branch_decision = (forward_rs1 >= forward_rs2);
        3'b010, 3'b011: illegal_branch  = 1'b1;
      endcase
    end
  end

  // Not gated by stall_EX; the hazard unit qualifies it.
  assign mispredict = meet_branch_ID_EX_o & ~illegal_branch & (branch_decision ^ ex_pred_taken);
  assign upd        = meet_branch_ID_EX_o & ~stall_EX & ~illegal_branch;

  always_comb begin
    ex_ctr      = bht[ex_idx];
    ex_ctr_next = ex_ctr;
    if (branch_decision) begin
      if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + 2'b01;
    end else begin
      if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht[i] <= 2'b01;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd) begin
      bht[ex_idx] <= ex_ctr_next;
      if (branch_count != '1) branch_count <= branch_count + STAT_WIDTH'(1);
      if (mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + STAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed, table-driven bench for branch_resolve_bht plus a narrow-statistics instance.
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, meet, pred, stall, if_pt, dec, mis, ill;
  logic [2:0]  f3;
  logic [31:0] if_pc, ex_pc, rs1, rs2;
  logic [15:0] bcnt, mcnt;

  logic        s_rst, s_meet, s_pred, s_stall, s_if_pt, s_dec, s_mis, s_ill;
  logic [2:0]  s_f3;
  logic [31:0] s_if_pc, s_ex_pc, s_rs1, s_rs2;
  logic [3:0]  s_bcnt, s_mcnt;

  branch_resolve_bht dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pt),
    .meet_branch_ID_EX_o(meet), .funct3(f3), .forward_rs1(rs1), .forward_rs2(rs2),
    .ex_pc(ex_pc), .ex_pred_taken(pred), .stall_EX(stall),
    .branch_decision(dec), .mispredict(mis), .illegal_branch(ill),
    .branch_count(bcnt), .mispredict_count(mcnt)
  );

  branch_resolve_bht #(.STAT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(s_rst), .if_pc(s_if_pc), .if_pred_taken(s_if_pt),
    .meet_branch_ID_EX_o(s_meet), .funct3(s_f3), .forward_rs1(s_rs1), .forward_rs2(s_rs2),
    .ex_pc(s_ex_pc), .ex_pred_taken(s_pred), .stall_EX(s_stall),
    .branch_decision(s_dec), .mispredict(s_mis), .illegal_branch(s_ill),
    .branch_count(s_bcnt), .mispredict_count(s_mcnt)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        meet;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
    logic        exp_dec;
    logic        exp_ill;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'b100, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{3'b101, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b110, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b111, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{3'b010, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'b011, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'b000, 1'b1, 32'h7,         32'h7, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b001, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b101, 1'b1, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{3'b110, 1'b1, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b0; meet = 1'b0; pred = 1'b0; stall = 1'b0; f3 = 3'b000;
    if_pc = '0; ex_pc = '0; rs1 = '0; rs2 = '0;
    s_rst = 1'b1; s_meet = 1'b0; s_pred = 1'b0; s_stall = 1'b0; s_f3 = 3'b000;
    s_if_pc = '0; s_ex_pc = 32'h40; s_rs1 = 32'h5; s_rs2 = 32'h5;
    #2;

    // Reset defaults
    do_reset();
    s_rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i * 4);
      #1;
      check($sformatf("reset_pred[%0d]", i), {31'b0, if_pt}, 32'd0);
    end
    check("reset_bcnt", {16'b0, bcnt}, 32'd0);
    check("reset_mcnt", {16'b0, mcnt}, 32'd0);

    // Compare coverage, stalled so no state moves
    ex_pc = 32'h80;
    stall = 1'b1;
    for (int i = 0; i < 12; i++) begin
      f3 = vecs[i].f3; meet = vecs[i].meet; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      pred = vecs[i].pred;
      #1;
      check($sformatf("vec%0d_dec", i), {31'b0, dec}, {31'b0, vecs[i].exp_dec});
      check($sformatf("vec%0d_ill", i), {31'b0, ill}, {31'b0, vecs[i].exp_ill});
      check($sformatf("vec%0d_mis", i), {31'b0, mis}, {31'b0, vecs[i].exp_mis});
      tick();
    end
    check("stalled_vecs_bcnt", {16'b0, bcnt}, 32'd0);
    // Unstalled illegal branch must not touch table or counts
    stall = 1'b0; meet = 1'b1; f3 = 3'b010; pred = 1'b0;
    tick();
    meet = 1'b0;
    tick();
    if_pc = 32'h80;
    #1;
    check("illegal_bcnt", {16'b0, bcnt}, 32'd0);
    check("illegal_mcnt", {16'b0, mcnt}, 32'd0);
    check("illegal_pred", {31'b0, if_pt}, 32'd0);

    // Training and saturation at 0x40: counter 01 -> 10 -> 11 -> 11, then not-taken -> 10
    ex_pc = 32'h40; if_pc = 32'h40; rs1 = 32'h5; rs2 = 32'h5; f3 = 3'b000; meet = 1'b1;
    pred = 1'b0;
    #1;
    check("train1_mis", {31'b0, mis}, 32'd1);
    check("train1_pred_before", {31'b0, if_pt}, 32'd0);
    tick();
    check("train1_pred_after", {31'b0, if_pt}, 32'd1);
    pred = 1'b1;
    #1;
    check("train2_mis", {31'b0, mis}, 32'd0);
    tick();
    #1;
    check("train3_mis", {31'b0, mis}, 32'd0);
    tick();
    f3 = 3'b001;
    #1;
    check("train4_dec", {31'b0, dec}, 32'd0);
    check("train4_mis", {31'b0, mis}, 32'd1);
    tick();
    meet = 1'b0;
    #1;
    check("train4_pred", {31'b0, if_pt}, 32'd1);
    check("train_bcnt", {16'b0, bcnt}, 32'd4);
    check("train_mcnt", {16'b0, mcnt}, 32'd2);
    // 10 -> 01 on one more not-taken proves the counter sat at 10, not 11
    meet = 1'b1; f3 = 3'b001;
    tick();
    meet = 1'b0;
    #1;
    check("train5_pred", {31'b0, if_pt}, 32'd0);

    // Aliasing and same-cycle lookup
    do_reset();
    ex_pc = 32'h40; if_pc = 32'h140; f3 = 3'b000; meet = 1'b1; pred = 1'b0;
    #1;
    check("alias_same_cycle", {31'b0, if_pt}, 32'd0);
    tick();
    meet = 1'b0;
    #1;
    check("alias_next_cycle", {31'b0, if_pt}, 32'd1);

    // Stall, release, then reset overriding an update
    do_reset();
    ex_pc = 32'h80; if_pc = 32'h80; f3 = 3'b000; meet = 1'b1; pred = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_bcnt", i), {16'b0, bcnt}, 32'd0);
      check($sformatf("stall%0d_mcnt", i), {16'b0, mcnt}, 32'd0);
      check($sformatf("stall%0d_pred", i), {31'b0, if_pt}, 32'd0);
      check($sformatf("stall%0d_mis", i), {31'b0, mis}, 32'd1);
    end
    stall = 1'b0;
    tick();
    meet = 1'b0;
    tick();
    check("release_bcnt", {16'b0, bcnt}, 32'd1);
    check("release_mcnt", {16'b0, mcnt}, 32'd1);
    check("release_pred", {31'b0, if_pt}, 32'd1);
    meet = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; meet = 1'b0;
    #1;
    check("rst_upd_pred", {31'b0, if_pt}, 32'd0);
    check("rst_upd_bcnt", {16'b0, bcnt}, 32'd0);
    check("rst_upd_mcnt", {16'b0, mcnt}, 32'd0);
    // A single taken update from 01 flips the prediction, so the entry really is 01
    meet = 1'b1;
    tick();
    meet = 1'b0;
    #1;
    check("rst_upd_entry01", {31'b0, if_pt}, 32'd1);

    // Saturating 4-bit statistics: 17 mispredicting branches
    s_meet = 1'b1; s_pred = 1'b0; s_f3 = 3'b000;
    for (int i = 0; i < 17; i++) begin
      #1;
      if (i == 0) check("sat_first_mis", {31'b0, s_mis}, 32'd1);
      tick();
      if (i == 14) begin
        check("sat_bcnt_15", {28'b0, s_bcnt}, 32'd15);
        check("sat_mcnt_15", {28'b0, s_mcnt}, 32'd15);
      end
    end
    s_meet = 1'b0;
    tick();
    check("sat_bcnt", {28'b0, s_bcnt}, 32'd15);
    check("sat_mcnt", {28'b0, s_mcnt}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
